// File: rtl/ik_sched_pkg.sv
// ik_sched_pkg: shared schedule constants, state enum and multiplier window table
package ik_sched_pkg;
  localparam int COUNT_W = 8;
  localparam logic [COUNT_W-1:0] LAST_COUNT_DEF = 8'd99;
  localparam int N_WIN = 6;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef struct packed {
    logic [COUNT_W-1:0] lo;
    logic [COUNT_W-1:0] hi;
  } win_t;
  localparam win_t WINDOWS [N_WIN] = '{
    '{8'd29, 8'd35}, '{8'd42, 8'd48}, '{8'd54, 8'd60},
    '{8'd66, 8'd72}, '{8'd78, 8'd84}, '{8'd90, 8'd96}
  };
endpackage

// File: rtl/mult_window_decode.sv
// mult_window_decode: maps schedule count to multiplier ownership and external-issue guard
//   i_count        schedule count
//   i_busy         sequencer is running
//   o_jac_mult_sel count lies inside a Jacobian multiplier window
//   o_guard        an issue now would still be in flight during some window
module mult_window_decode
  import ik_sched_pkg::*;
#(
  parameter int MULT_LAT = 5
) (
  input  logic [COUNT_W-1:0] i_count,
  input  logic               i_busy,
  output logic               o_jac_mult_sel,
  output logic               o_guard
);
  logic [COUNT_W:0] w_last;
  assign w_last = {1'b0, i_count} + (COUNT_W+1)'(MULT_LAT);
  always_comb begin
    o_jac_mult_sel = 1'b0;
    o_guard = 1'b0;
    for (int i = 0; i < N_WIN; i++) begin
      o_jac_mult_sel |= i_busy && i_count >= WINDOWS[i].lo && i_count <= WINDOWS[i].hi;
      o_guard |= i_busy && i_count <= WINDOWS[i].hi && w_last >= {1'b0, WINDOWS[i].lo};
    end
  end
endmodule

// File: rtl/jacobian_sequencer.sv
// jacobian_sequencer: drives the Jacobian en/count schedule and shares the array multiplier
//   clk, reset          clock, async active-high reset
//   start, abort, stall run request, abort running schedule, freeze schedule
//   busy, done          running, one-cycle completion pulse
//   en, count           schedule enable and counter to the Jacobian stage
//   jac_mult_sel        multiplier owned by the Jacobian stage
//   ext_mult_req/gnt    external single-slot multiplier request and grant
module jacobian_sequencer
  import ik_sched_pkg::*;
#(
  parameter logic [COUNT_W-1:0] LAST_COUNT = LAST_COUNT_DEF,
  parameter int MULT_LAT = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               en,
  output logic [COUNT_W-1:0] count,
  output logic               jac_mult_sel,
  input  logic               ext_mult_req,
  output logic               ext_mult_gnt
);
  state_t r_state;
  logic [COUNT_W-1:0] r_count;
  logic w_guard;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else
      case (r_state)
        S_IDLE:
          if (start) begin
            r_state <= S_RUN;
            r_count <= '0;
          end
        S_RUN:
          if (abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (!stall) begin
            if (r_count == LAST_COUNT) begin
              r_state <= S_DONE;
              r_count <= '0;
            end else
              r_count <= r_count + 1'b1;
          end
        default: r_state <= S_IDLE;
      endcase
  assign busy = r_state == S_RUN;
  assign done = r_state == S_DONE;
  assign en = busy && !stall;
  assign count = r_count;
  assign ext_mult_gnt = ext_mult_req && !w_guard;
  mult_window_decode #(.MULT_LAT(MULT_LAT)) u_dec (
    .i_count(r_count),
    .i_busy(busy),
    .o_jac_mult_sel(jac_mult_sel),
    .o_guard(w_guard)
  );
endmodule

// File: tb/tb_jacobian_sequencer.sv
// tb_jacobian_sequencer: randomized and directed checks against a behavioural schedule model
module tb_jacobian_sequencer;
  logic clk = 0, reset = 1, start = 0, abort = 0, stall = 0, ext_mult_req = 0;
  logic busy, done, en, jac_mult_sel, ext_mult_gnt;
  logic [7:0] count;
  int checks = 0, failures = 0;
  int m_state = 0, m_cnt = 0;
  bit occ [0:255];
  int gnt_at [0:255];

  jacobian_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .stall(stall),
    .busy(busy), .done(done), .en(en), .count(count), .jac_mult_sel(jac_mult_sel),
    .ext_mult_req(ext_mult_req), .ext_mult_gnt(ext_mult_gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // model: 0 idle, 1 running with m_cnt progress, 2 completion cycle
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_state = 0;
      m_cnt = 0;
    end else if (m_state == 0) begin
      if (start) begin
        m_state = 1;
        m_cnt = 0;
      end
    end else if (m_state == 2)
      m_state = 0;
    else if (abort) begin
      m_state = 0;
      m_cnt = 0;
    end else if (!stall) begin
      if (m_cnt == 99) begin
        m_state = 2;
        m_cnt = 0;
      end else
        m_cnt++;
    end

  always @(negedge clk) begin
    bit g;
    g = 0;
    if (m_state == 1)
      for (int k = 0; k <= 5; k++) g |= occ[m_cnt + k];
    check("busy", busy, m_state == 1);
    check("done", done, m_state == 2);
    check("en", en, m_state == 1 && !stall);
    check("count", count, m_cnt);
    check("jac_mult_sel", jac_mult_sel, m_state == 1 && occ[m_cnt]);
    check("ext_mult_gnt", ext_mult_gnt, ext_mult_req && !g);
  end

  task automatic run_job(input int stall_at, input int stall_len, input int abort_at,
                         input int req_mode, input bit extra, input bit rnd,
                         output int lat, output int ndone, output int nbusy, output bit aborted);
    int left, after;
    bit hold;
    left = stall_len;
    after = -1;
    lat = -1;
    ndone = 0;
    nbusy = 0;
    aborted = 0;
    start = 1;
    abort = 0;
    stall = 0;
    ext_mult_req = req_mode == 1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      hold = busy && int'(count) == stall_at && left > 0;
      if (hold) left--;
      start = (extra && ((busy && (count == 10 || count == 99)) || done)) ||
              (rnd && busy && $urandom_range(0, 3) == 0);
      stall = hold || (rnd && busy && $urandom_range(0, 7) == 0);
      abort = busy && (int'(count) == abort_at || (rnd && $urandom_range(0, 299) == 0));
      ext_mult_req = req_mode == 1 ? 1'b1 : req_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (busy) nbusy++;
      if (hold) begin
        check("stall_en", en, 0);
        check("stall_sel", jac_mult_sel, 1);
      end
      if (req_mode == 1 && busy && !stall) gnt_at[count] = int'(ext_mult_gnt);
      if (abort) aborted = 1;
      if (after < 0 && (done || aborted)) after = i;
      if (after >= 0 && i >= after + 2) break;
    end
    start = 0;
    abort = 0;
    stall = 0;
    ext_mult_req = 0;
    if (lat < 0 && !aborted) check("job_timeout", 0, 1);
  endtask

  initial begin
    int ws [6] = '{29, 42, 54, 66, 78, 90};
    int lat, nd, nb;
    bit ab;
    for (int i = 0; i < 6; i++)
      for (int v = ws[i]; v <= ws[i] + 6; v++) occ[v] = 1;
    for (int i = 0; i < 256; i++) gnt_at[i] = -1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_en", en, 0);

    run_job(999, 0, 999, 0, 0, 0, lat, nd, nb, ab);
    check("plain_latency", lat, 101);
    check("plain_ndone", nd, 1);
    check("plain_busy_cycles", nb, 100);

    run_job(30, 3, 999, 0, 0, 0, lat, nd, nb, ab);
    check("stall_latency", lat, 104);
    check("stall_busy_cycles", nb, 103);

    run_job(999, 0, 999, 1, 0, 0, lat, nd, nb, ab);
    check("req_latency", lat, 101);
    for (int c = 0; c < 100; c++)
      check($sformatf("gnt_at_%0d", c), gnt_at[c], (c <= 23 || c == 36 || c >= 97) ? 1 : 0);

    run_job(999, 0, 60, 0, 0, 0, lat, nd, nb, ab);
    check("abort_flag", ab, 1);
    check("abort_ndone", nd, 0);
    check("abort_busy_cycles", nb, 61);
    run_job(999, 0, 999, 0, 0, 0, lat, nd, nb, ab);
    check("after_abort_latency", lat, 101);

    run_job(999, 0, 999, 0, 1, 0, lat, nd, nb, ab);
    check("extra_start_latency", lat, 101);
    check("extra_start_ndone", nd, 1);

    for (int j = 0; j < 5; j++) begin
      run_job(999, 0, 999, 2, 0, 1, lat, nd, nb, ab);
      check("rnd_done_or_abort", nd + int'(ab), 1);
    end

    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int i = 0; i < 200 && !(busy && count == 45); i++) begin
      @(posedge clk);
      #1;
    end
    check("reach_45", count, 45);
    #2 reset = 1;
    #1;
    check("areset_busy", busy, 0);
    check("areset_done", done, 0);
    check("areset_en", en, 0);
    check("areset_count", count, 0);
    check("areset_sel", jac_mult_sel, 0);
    check("areset_gnt", ext_mult_gnt, 0);
    @(posedge clk);
    #2 reset = 0;
    run_job(999, 0, 999, 2, 0, 0, lat, nd, nb, ab);
    check("post_reset_latency", lat, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/jacobian_sequencer.md
# jacobian_sequencer

Schedule controller for the full-Jacobian datapath. It accepts a start request, then drives the free-running `en`/`count` schedule that the Jacobian stage decodes: joint latch at counts 28–89, array-multiplier issue/collect at counts 29–96, and result write at count 98. It also shares the 9-lane array multiplier with one external requester, such as the downstream transpose/update stage, during the gaps in the schedule. It sits between the top-level IK controller and the `ifc_jacobian` instance.

## Interface
Parameters:
- `LAST_COUNT`, default 8'd99: final schedule count; the Jacobian matrix is valid once this count has been consumed.
- `MULT_LAT`, default 5: array-multiplier issue-to-result latency in cycles, used for external grant guarding.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request one Jacobian computation; sampled only in IDLE.
- `abort`  in  1  synchronous abort of a running schedule.
- `stall`  in  1  freeze the schedule this cycle (upstream operand not ready).
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the matrix is valid.
- `en`  out  1  Jacobian enable.
- `count`  out  8  schedule counter to the Jacobian stage.
- `jac_mult_sel`  out  1  1 means the array-multiplier inputs and results belong to the Jacobian stage.
- `ext_mult_req`  in  1  external requester wants one multiplier issue slot.
- `ext_mult_gnt`  out  1  issue slot granted this cycle.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when `en` is high and `count==LAST_COUNT`.
  - DONE → IDLE unconditionally after one cycle.
  - RUN → IDLE on `abort`. `abort` has priority over every other transition.
- `count`:
  - Loads 0 on the IDLE → RUN transition.
  - In RUN, increments by 1 on each cycle with `en` high.
  - Holds when `stall` is high.
  - Returns to 0 in IDLE and on abort.
  - Never wraps, because the end condition occurs before 8'hFF.
- `en = (state==RUN) && !stall`. This is combinational from the state register and `stall`.
- `busy = (state==RUN)`. `done = (state==DONE)`.
- Multiplier windows are the counts W = {29–35, 42–48, 54–60, 66–72, 78–84, 90–96}.
  - `jac_mult_sel` is 1 in RUN when `count` is in W, including while stalled, so the held operands stay routed.
  - `jac_mult_sel` is 0 otherwise.
- External grant:
  - `ext_mult_gnt = ext_mult_req && !guard`.
  - `guard` is high when, in RUN, the issued op's result interval [count, count+MULT_LAT] overlaps any window in W.
  - In IDLE and DONE, `guard` is 0.
  - The grant is combinational, one slot per cycle, with no queue. The requester holds `req` until it is granted.
- A `start` received in RUN or DONE is ignored. The block does not buffer it.
- Abort mid-window:
  - `en` drops immediately.
  - The Jacobian registers keep stale data.
  - `done` is not pulsed.
  - External grants resume the next cycle.

## Timing
- Reset values: state IDLE; `count`=0; `en`, `busy`, `done`, `jac_mult_sel`, `ext_mult_gnt` all 0.
- `start` at edge t gives RUN at t+1 with `count`=0 and `en`=1 (if not stalled).
- Latency from start to `done` is `LAST_COUNT`+2 cycles plus the number of stalled cycles. With defaults and no stalls, this is 101.
- `done` is high for exactly one cycle. `busy` is low in that cycle.
- A new `start` is accepted at the earliest in the cycle after `done`, which is back in IDLE.
- `stall` and `abort` in the same cycle: abort wins.
- `stall` on the final count: completion is deferred until a non-stalled cycle at `LAST_COUNT`.
- Reset asserted mid-RUN: all outputs clear asynchronously.

## Structure
- The shared package `ik_sched_pkg` holds:
  - the state enum;
  - `COUNT_W`=8;
  - the window table as a constant array of {start, end} pairs;
  - `LAST_COUNT_DEF`.
- One sub-module: `mult_window_decode`. It is combinational and maps `count`, `busy` and `MULT_LAT` to `jac_mult_sel` and `guard`. It is reused by the inverse-stage sequencer.

## Test plan
- Reset, then `start` for 1 cycle with no stall:
  - `count` steps 0..99;
  - `done` pulses at cycle 101;
  - `busy` is high for 100 cycles.
- Run with `stall` high for 3 cycles at `count`=30:
  - `count` holds at 30 and `en`=0 for those 3 cycles;
  - `jac_mult_sel` stays 1;
  - `done` arrives at cycle 104.
- `ext_mult_req` held high for the whole run:
  - it is granted at counts 0–23;
  - it is denied at counts 24–35 and 37–48;
  - it is granted at 36 and again after 96.
  - Check every denied count against W with `MULT_LAT`=5.
- `abort` at `count`=60:
  - next cycle is IDLE with `count`=0;
  - no `done`;
  - a new `start` is accepted immediately.
- `start` pulsed at counts 10 and 99, and in DONE: all are ignored, and exactly one `done` is produced.
- Asynchronous `reset` asserted mid-cycle at `count`=45: all outputs go to 0 before the next edge.
